ola_capture: RTL and testbench
==============================

// Module: ola_capture
// PURPOSE
//  Sample capture buffer directly downstream of ola_trigger: consumes its out_valid/out_sample/out_trigger
//  stream and stores samples in a circular RAM. It retains pre-trigger history and stops after a
//  programmed number of post-trigger samples. The captured window is then streamed out oldest-first
//  over a valid/ready port toward the host readout logic.
// PARAMETERS
//  sample_width  8   width of one sample
//  addr_width    10  RAM address width; depth = 2**addr_width samples
// PORTS
//  clock          input   1             single clock; all logic on posedge
//  reset          input   1             synchronous, active-high
//  in_arm         input   1             start a capture (pulse)
//  in_abort       input   1             cancel any activity, return to IDLE
//  in_post_count  input   addr_width+1  post-trigger samples incl. trigger sample; latched on accepted arm
//  in_valid       input   1             sample strobe from ola_trigger.out_valid
//  in_sample      input   sample_width  from ola_trigger.out_sample
//  in_trigger     input   1             from ola_trigger.out_trigger; qualifies same-cycle in_sample
//  rd_ready       input   1             readout sink ready
//  out_valid      output  1             readout sample valid
//  out_sample     output  sample_width  readout sample, oldest first
//  out_state      output  3             current state code
//  out_done       output  1             high in DONE
// BEHAVIOUR
//  - Reset: state IDLE, wr_ptr=0, fill=0, out_valid=0, out_sample=0, out_done=0, out_state=IDLE.
//  - States: IDLE, ARMED, POST, READOUT, DONE.
//  - IDLE/DONE + in_arm: wr_ptr<=0, fill<=0, post_left<=clamp(in_post_count), -> ARMED. Arm elsewhere ignored.
//    clamp: 0 -> 1; values > depth -> depth.
//  - ARMED: each in_valid writes in_sample at wr_ptr; wr_ptr++ (wraps mod depth); fill++ saturating at depth.
//    in_valid && in_trigger: write sample, count it as first post sample (post_left--), -> POST,
//    or straight to READOUT if post_left was 1. in_trigger with in_valid=0 ignored.
//  - POST: each in_valid writes as above, post_left--; write making post_left 0 -> READOUT. Triggers ignored.
//  - READOUT entry: rd_ptr <= wr_ptr - fill (mod depth), rd_left <= fill (after final write counted).
//    Sync-read RAM, 1-cycle latency; one output register + one skid entry so out_valid can be
//    sustained at 1 sample/cycle while rd_ready=1. out_sample/out_valid held stable while
//    out_valid && !rd_ready. Transfer = out_valid && rd_ready. After transfer of the last sample -> DONE.
//  - DONE: out_done=1, out_valid=0; RAM contents unchanged until next arm.
//  - in_abort (any state): -> IDLE next cycle, out_valid<=0, pending reads discarded; abort beats arm.
//  - Arm in same cycle as in_valid/in_trigger from IDLE: sample not stored, trigger not seen.
//  - Samples with in_valid in IDLE/READOUT/DONE are dropped; no RAM writes outside ARMED/POST.
//  - reset mid-operation: identical to power-on reset; RAM contents not cleared.
// STRUCTURE
//  - ola_capture_pkg: state codes (IDLE=0, ARMED=1, POST=2, READOUT=3, DONE=4), state width constant.
//  - Sub-module ola_capture_ram: simple dual-port, 1 write port, 1 sync read port, no reset on array.
//  - Top holds FSM, pointers, counters, output/skid registers.
// TESTING  (addr_width=4, depth 16, sample = index)
//  1 arm, post=4, feed 0..9, trigger on 5 -> READOUT after sample 8; reads 0x00..0x08 (9), then out_done=1.
//  2 arm, post=4, feed 0..39, trigger on 30 -> wrap; reads exactly 18..33 (16 samples), oldest first.
//  3 case 1 with rd_ready pattern 1,0,1,0,0,1.. -> out_sample stable while stalled, no drop/duplicate.
//  4 arm, trigger on 3 with in_valid=0 then valid trigger on 6, post=0 -> post treated as 1; reads 0..6.
//  5 in_abort during POST -> IDLE next cycle, out_valid=0; re-arm, case 1 passes again; arm during POST ignored.
//  6 reset asserted mid-READOUT -> next cycle out_valid=0, out_state=IDLE, out_done=0.

Source files
------------

// File: rtl/ola_capture_pkg.sv
// Shared state codes for the ola_capture sample buffer.
package ola_capture_pkg;
    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_POST    = 3'd2,
        ST_READOUT = 3'd3,
        ST_DONE    = 3'd4
    } state_e;
endpackage

// File: rtl/ola_capture_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port (1-cycle latency).
module ola_capture_ram #(
    parameter int sample_width = 8,
    parameter int addr_width   = 10
) (
    input  logic                    clock,
    input  logic                    wr_en,
    input  logic [addr_width-1:0]   wr_addr,
    input  logic [sample_width-1:0] wr_data,
    input  logic                    rd_en,
    input  logic [addr_width-1:0]   rd_addr,
    output logic [sample_width-1:0] rd_data
);
    logic [sample_width-1:0] mem_q [2**addr_width];
    logic [sample_width-1:0] rd_data_q;

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem_q[rd_addr];
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/ola_capture.sv
// Circular pre/post-trigger capture buffer with an oldest-first valid/ready readout port.
module ola_capture
    import ola_capture_pkg::*;
#(
    parameter int sample_width = 8,
    parameter int addr_width   = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_arm,
    input  logic                    in_abort,
    input  logic [addr_width:0]     in_post_count,
    input  logic                    in_valid,
    input  logic [sample_width-1:0] in_sample,
    input  logic                    in_trigger,
    input  logic                    rd_ready,
    output logic                    out_valid,
    output logic [sample_width-1:0] out_sample,
    output logic [STATE_W-1:0]      out_state,
    output logic                    out_done
);
    localparam logic [addr_width:0] DEPTH_C = {1'b1, {addr_width{1'b0}}};
    localparam logic [addr_width:0] ONE_C   = (addr_width+1)'(1);

    state_e                  state_q, state_d;
    logic [addr_width-1:0]   wr_ptr_q, wr_ptr_d;
    logic [addr_width:0]     fill_q, fill_d;
    logic [addr_width:0]     post_left_q, post_left_d;
    logic [addr_width-1:0]   rd_ptr_q, rd_ptr_d;
    logic [addr_width:0]     rd_left_q, rd_left_d;
    logic                    rd_pend_q, rd_pend_d;
    logic                    out_valid_q, out_valid_d;
    logic [sample_width-1:0] out_sample_q, out_sample_d;
    logic                    skid_valid_q, skid_valid_d;
    logic [sample_width-1:0] skid_q, skid_d;

    logic                    we;
    logic                    rd_en;
    logic [sample_width-1:0] rd_data;
    logic [addr_width:0]     post_clamped;
    logic                    pop;
    logic [1:0]              occ;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        post_left_d  = post_left_q;
        rd_ptr_d     = rd_ptr_q;
        rd_left_d    = rd_left_q;
        rd_pend_d    = 1'b0;
        out_valid_d  = 1'b0;
        out_sample_d = out_sample_q;
        skid_valid_d = 1'b0;
        skid_d       = skid_q;
        we           = 1'b0;
        rd_en        = 1'b0;
        pop          = out_valid_q && rd_ready;
        occ          = 2'(out_valid_q) + 2'(skid_valid_q) + 2'(rd_pend_q) - 2'(pop);

        if (in_post_count == '0)         post_clamped = ONE_C;
        else if (in_post_count > DEPTH_C) post_clamped = DEPTH_C;
        else                              post_clamped = in_post_count;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (in_arm) begin
                    wr_ptr_d    = '0;
                    fill_d      = '0;
                    post_left_d = post_clamped;
                    state_d     = ST_ARMED;
                end
            end
            ST_ARMED, ST_POST: begin
                if (in_valid) begin
                    we       = 1'b1;
                    wr_ptr_d = wr_ptr_q + addr_width'(1);
                    fill_d   = (fill_q == DEPTH_C) ? fill_q : fill_q + ONE_C;
                    if (state_q == ST_POST || in_trigger) begin
                        post_left_d = post_left_q - ONE_C;
                        state_d     = ST_POST;
                        if (post_left_q == ONE_C) begin
                            // Oldest retained sample sits fill entries behind the write pointer.
                            state_d   = ST_READOUT;
                            rd_ptr_d  = wr_ptr_d - fill_d[addr_width-1:0];
                            rd_left_d = fill_d;
                        end
                    end
                end
            end
            ST_READOUT: begin
                // Output register is oldest, then skid, then the RAM word landing this cycle.
                if (!out_valid_q || rd_ready) begin
                    if (skid_valid_q) begin
                        out_valid_d  = 1'b1;
                        out_sample_d = skid_q;
                        skid_valid_d = rd_pend_q;
                        skid_d       = rd_data;
                    end else if (rd_pend_q) begin
                        out_valid_d  = 1'b1;
                        out_sample_d = rd_data;
                    end
                end else begin
                    out_valid_d  = 1'b1;
                    skid_valid_d = skid_valid_q || rd_pend_q;
                    if (rd_pend_q) skid_d = rd_data;
                end
                // Issue only when the output+skid pair can absorb the returning word.
                if (rd_left_q != '0 && occ < 2'd2) begin
                    rd_en     = 1'b1;
                    rd_pend_d = 1'b1;
                    rd_ptr_d  = rd_ptr_q + addr_width'(1);
                    rd_left_d = rd_left_q - ONE_C;
                end
                if (pop && rd_left_q == '0 && !rd_pend_q && !skid_valid_q) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (in_abort) begin
            state_d      = ST_IDLE;
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            rd_pend_d    = 1'b0;
            rd_en        = 1'b0;
            we           = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            post_left_q  <= '0;
            rd_ptr_q     <= '0;
            rd_left_q    <= '0;
            rd_pend_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_sample_q <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            post_left_q  <= post_left_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_left_q    <= rd_left_d;
            rd_pend_q    <= rd_pend_d;
            out_valid_q  <= out_valid_d;
            out_sample_q <= out_sample_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
        end
    end

    ola_capture_ram #(
        .sample_width(sample_width),
        .addr_width  (addr_width)
    ) u_ram (
        .clock  (clock),
        .wr_en  (we && !reset),
        .wr_addr(wr_ptr_q),
        .wr_data(in_sample),
        .rd_en  (rd_en && !reset),
        .rd_addr(rd_ptr_q),
        .rd_data(rd_data)
    );

    assign out_valid  = out_valid_q;
    assign out_sample = out_sample_q;
    assign out_state  = state_q;
    assign out_done   = (state_q == ST_DONE);
endmodule

// File: tb/tb_ola_capture.sv
// Directed + randomized bench for ola_capture against a list-based capture-window model.
module tb_ola_capture;
    localparam int SW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset, in_arm, in_abort, in_valid, in_trigger, rd_ready;
    logic [AW:0]   in_post_count;
    logic [SW-1:0] in_sample;
    logic          out_valid, out_done;
    logic [SW-1:0] out_sample;
    logic [2:0]    out_state;

    int total = 0;
    int bad = 0;

    logic [SW-1:0] fs[$];
    bit            fv[$];
    bit            ft[$];
    logic [SW-1:0] exp_q[$];
    int            post_cfg;

    ola_capture #(.sample_width(SW), .addr_width(AW)) dut (
        .clock(clock), .reset(reset), .in_arm(in_arm), .in_abort(in_abort),
        .in_post_count(in_post_count), .in_valid(in_valid), .in_sample(in_sample),
        .in_trigger(in_trigger), .rd_ready(rd_ready), .out_valid(out_valid),
        .out_sample(out_sample), .out_state(out_state), .out_done(out_done)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic arm(input int post, input bit junk);
        in_arm = 1'b1;
        in_post_count = post[AW:0];
        in_valid = junk;
        in_trigger = junk;
        in_sample = 8'hAA;
        tick();
        in_arm = 1'b0;
        in_valid = 1'b0;
        in_trigger = 1'b0;
        post_cfg = post;
        fs.delete();
        fv.delete();
        ft.delete();
    endtask

    task automatic feed(input logic [SW-1:0] s, input bit v, input bit t);
        in_sample = s;
        in_valid = v;
        in_trigger = t;
        fs.push_back(s);
        fv.push_back(v);
        ft.push_back(t);
        tick();
        in_valid = 1'b0;
        in_trigger = 1'b0;
    endtask

    // Expected window = last min(stored, DEPTH) samples of everything stored since arm.
    task automatic build_exp;
        logic [SW-1:0] stored[$];
        int p, left;
        bit seen;
        p = (post_cfg == 0) ? 1 : (post_cfg > DEPTH) ? DEPTH : post_cfg;
        seen = 1'b0;
        left = 0;
        exp_q.delete();
        foreach (fv[i]) begin
            if (fv[i]) begin
                stored.push_back(fs[i]);
                if (!seen && ft[i]) begin
                    seen = 1'b1;
                    left = p;
                end
                if (seen) begin
                    left--;
                    if (left == 0) break;
                end
            end
        end
        while (stored.size() > DEPTH) void'(stored.pop_front());
        exp_q = stored;
    endtask

    task automatic readout(input int mode);
        logic [SW-1:0] got[$];
        logic [SW-1:0] held;
        bit stalled;
        int cyc;
        int pat[6];
        pat = '{1, 0, 1, 0, 0, 1};
        stalled = 1'b0;
        held = '0;
        cyc = 0;
        build_exp();
        while (got.size() < exp_q.size() && cyc < 400) begin
            rd_ready = (mode == 0) || (mode == 1 && pat[cyc % 6] == 1) ||
                       (mode == 2 && $urandom_range(2, 0) != 0);
            if (stalled) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_hold", 32'(out_sample), 32'(held));
            end
            if (out_valid && rd_ready) got.push_back(out_sample);
            stalled = out_valid && !rd_ready;
            held = out_sample;
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        chk("rd_count", 32'(got.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) if (i < got.size()) chk("rd_data", 32'(got[i]), 32'(exp_q[i]));
        chk("done_flag", 32'(out_done), 32'd1);
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_state", 32'(out_state), 32'd4);
    endtask

    task automatic case1(input int mode);
        arm(4, 1'b1);
        chk("armed_state", 32'(out_state), 32'd1);
        for (int i = 0; i < 10; i++) feed(8'(i), 1'b1, i == 5);
        readout(mode);
    endtask

    initial begin
        reset = 1'b1; in_arm = 1'b0; in_abort = 1'b0; in_valid = 1'b0;
        in_trigger = 1'b0; rd_ready = 1'b0; in_post_count = '0; in_sample = '0;
        post_cfg = 0;
        @(negedge clock);
        tick();
        chk("rst_state", 32'(out_state), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sample", 32'(out_sample), 32'd0);
        chk("rst_done", 32'(out_done), 32'd0);
        reset = 1'b0;
        tick();

        // Basic capture, including arm with a same-cycle sample/trigger that must be ignored.
        case1(0);

        // Wrap: only the most recent DEPTH samples survive.
        arm(4, 1'b0);
        for (int i = 0; i < 40; i++) feed(8'(i), 1'b1, i == 30);
        readout(0);

        // Back-pressure pattern.
        case1(1);

        // Invalid trigger ignored, post=0 clamps to 1.
        arm(0, 1'b0);
        for (int i = 0; i < 3; i++) feed(8'(i), 1'b1, 1'b0);
        feed(8'h99, 1'b0, 1'b1);
        for (int i = 3; i < 6; i++) feed(8'(i), 1'b1, 1'b0);
        feed(8'd6, 1'b1, 1'b1);
        readout(0);

        // Arm ignored in POST, abort returns to IDLE, re-arm works.
        arm(4, 1'b0);
        for (int i = 0; i < 7; i++) feed(8'(i), 1'b1, i == 5);
        chk("post_state", 32'(out_state), 32'd2);
        in_arm = 1'b1;
        in_post_count = 5'd1;
        tick();
        in_arm = 1'b0;
        chk("arm_in_post", 32'(out_state), 32'd2);
        feed(8'd7, 1'b1, 1'b0);
        chk("post_left", 32'(out_state), 32'd2);
        in_abort = 1'b1;
        tick();
        in_abort = 1'b0;
        chk("abort_state", 32'(out_state), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_done", 32'(out_done), 32'd0);
        case1(0);

        // Reset in the middle of readout.
        arm(4, 1'b0);
        for (int i = 0; i < 10; i++) feed(8'(i), 1'b1, i == 5);
        rd_ready = 1'b1;
        tick(); tick(); tick();
        chk("mid_rd_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        chk("mrst_valid", 32'(out_valid), 32'd0);
        chk("mrst_state", 32'(out_state), 32'd0);
        chk("mrst_done", 32'(out_done), 32'd0);
        reset = 1'b0;
        rd_ready = 1'b0;
        tick();
        case1(2);

        // Randomized captures with random post counts, gaps, stray triggers and back-pressure.
        for (int it = 0; it < 10; it++) begin
            int npre, nvalid;
            arm(int'($urandom_range(31, 0)), bit'($urandom_range(1, 0)));
            npre = int'($urandom_range(40, 0));
            for (int i = 0; i < npre; i++)
                feed(8'($urandom), $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0);
            feed(8'($urandom), 1'b1, 1'b1);
            nvalid = 0;
            while (nvalid < DEPTH + 1) begin
                bit v;
                v = $urandom_range(3, 0) != 0;
                if (v) nvalid++;
                feed(8'($urandom), v, $urandom_range(7, 0) == 0);
            end
            readout(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
